countdown_timer: RTL and testbench
==================================

# countdown_timer

Four-digit BCD MM:SS countdown timer. It is the down-counting counterpart of the stopwatch's cascaded up-counting digit chain: each digit borrows from the next instead of carrying into it. It loads a preset time, decrements once per tick while running, and flags expiry at 00:00. It sits beside the stopwatch digit chain and drives the same seven-segment display mux.

## Interface
- AUTO_RELOAD, default 0: when 1, reaching 00:00 reloads the last preset and keeps running instead of stopping in DONE.
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high; clears all state.
- tick, input, 1: one-clk-wide count strobe (1 Hz in system use); ignored unless in RUN.
- load, input, 1: capture the preset digits and enter IDLE.
- start, input, 1: begin or resume counting.
- stop, input, 1: pause counting.
- set_m1, set_m0, set_s1, set_s0, input, 4 each: preset BCD digits (minutes tens, minutes units, seconds tens, seconds units).
- m1, m0, s1, s0, output, 4 each: current BCD digits, registered.
- running, output, 1: high in RUN.
- done, output, 1: level, high in DONE.
- done_pulse, output, 1: one-clk strobe on every expiry, including AUTO_RELOAD expiries.

## Operation
- States:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSE: stopped mid-count.
  - DONE: expired.
- Reset: state IDLE; all digits 0; preset register 0000; running=0, done=0, done_pulse=0.
- Preset clamping on load:
  - set_s0 > 9 loads 9; set_s1 > 5 loads 5; set_m0 > 9 loads 9; set_m1 > 9 loads 9.
  - The clamped value is written to both the digits and the preset register.
- Priority when several inputs are high in the same cycle: reset > load > stop > start > tick.
- Transitions:
  - load, from any state: to IDLE, digits = clamped preset.
  - start, in IDLE or PAUSE: if digits == 0000, go to DONE and pulse done_pulse; otherwise go to RUN.
  - start in RUN or DONE: ignored.
  - stop in RUN: to PAUSE. stop in any other state: ignored.
  - tick in RUN: decrement (below).
- Decrement, BCD borrow chain:
  - s0: 0 becomes 9 and borrows; otherwise s0−1.
  - s1 (only on a borrow from s0): 0 becomes 5 and borrows; otherwise s1−1.
  - m0 (only on a borrow from s1): 0 becomes 9 and borrows; otherwise m0−1.
  - m1 (only on a borrow from m0): m1−1.
  - A borrow out of m1 cannot occur, because RUN is never entered at 0000.
- Expiry: a tick in RUN that produces 0000 pulses done_pulse in the same update.
  - AUTO_RELOAD=0: go to DONE; digits stay 0000.
  - AUTO_RELOAD=1: write the preset register into the digits and stay in RUN. The 0000 value is never presented.
  - AUTO_RELOAD=1 with preset 0000: go to DONE, since there is no meaningful reload.
- DONE persists until load or reset.

## Timing
- All outputs are registered.
- Digit change: one clock after the tick is sampled, i.e. visible on the edge after the tick cycle.
- running and done change on the same edge as the state transition that causes them.
- done_pulse is high for exactly the one cycle following the expiring edge.
- tick held high for N cycles in RUN produces N decrements; the block performs no edge detection.
- stop and tick in the same cycle: stop wins, no decrement, state PAUSE.
- load and tick in the same cycle: load wins, digits = preset, state IDLE.
- Reset mid-count: next edge gives digits 0000, IDLE, all flags 0, preset cleared.
- Maximum preset is 99:59, giving 5999 ticks to expiry.

## Test plan
- Reset then idle: digits 0000, running=0, done=0; ticks change nothing.
- Basic expiry: load 01:00, start, apply 60 ticks.
  - Sequence shows 00:59 after the first tick and 00:50 after the tenth.
  - done and done_pulse assert after the 60th tick; further ticks leave 0000.
- Borrow chain: load 10:00, start, one tick gives 09:59.
- Clamping: load set_s1=7, set_s0=12 gives s1=5, s0=9.
- Stop, priority and zero start:
  - stop and tick together in RUN at 00:05: result PAUSE at 00:05.
  - start resumes; the next tick gives 00:04.
  - start at 0000: DONE on the next edge with a single done_pulse.
- AUTO_RELOAD=1 with preset 00:02, start, 4 ticks:
  - digits read 01, then 02 with done_pulse, then 01, then 02 with done_pulse.
  - done stays 0 throughout.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control strobes, preset digits and display/status outputs of the MM:SS countdown timer.
// Every control input is a one-cycle strobe sampled on the clock edge; there is no valid/ready pair.
interface countdown_timer_if;
  logic       tick;
  logic       load;
  logic       start;
  logic       stop;
  logic [3:0] set_m1;
  logic [3:0] set_m0;
  logic [3:0] set_s1;
  logic [3:0] set_s0;
  logic [3:0] m1;
  logic [3:0] m0;
  logic [3:0] s1;
  logic [3:0] s0;
  logic       running;
  logic       done;
  logic       done_pulse;
  logic [1:0] fsm_state;

  modport master (
    output tick, load, start, stop,
    output set_m1, set_m0, set_s1, set_s0,
    input  m1, m0, s1, s0,
    input  running, done, done_pulse, fsm_state
  );

  modport slave (
    input  tick, load, start, stop,
    input  set_m1, set_m0, set_s1, set_s0,
    output m1, m0, s1, s0,
    output running, done, done_pulse, fsm_state
  );
endinterface

// File: rtl/countdown_timer.sv
// Four-digit BCD MM:SS countdown timer with borrow-chain decrement, pause, expiry flag
// and optional auto-reload of the last preset.
module countdown_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] digits;      // {m1, m0, s1, s0}
  logic [15:0] digits_nxt;
  logic [15:0] preset;
  logic [15:0] preset_nxt;
  logic        pulse_q;
  logic        pulse_nxt;

  logic [15:0] clamped;
  logic [15:0] dec_val;
  logic        b_s0;
  logic        b_s1;
  logic        b_m0;

  logic        do_load;
  logic        do_stop;
  logic        do_start;
  logic        do_tick;
  logic        digits_zero;
  logic        expire;
  logic        reload_ok;

  // Preset clamping: out-of-range BCD digits saturate to the largest legal digit.
  always_comb begin
    clamped[15:12] = (bus.set_m1 > 4'd9) ? 4'd9 : bus.set_m1;
    clamped[11:8]  = (bus.set_m0 > 4'd9) ? 4'd9 : bus.set_m0;
    clamped[7:4]   = (bus.set_s1 > 4'd5) ? 4'd5 : bus.set_s1;
    clamped[3:0]   = (bus.set_s0 > 4'd9) ? 4'd9 : bus.set_s0;
  end

  // Borrow chain: each digit only moves when everything below it wrapped.
  always_comb begin
    b_s0 = (digits[3:0] == 4'd0);
    b_s1 = b_s0 && (digits[7:4] == 4'd0);
    b_m0 = b_s1 && (digits[11:8] == 4'd0);

    dec_val[3:0] = b_s0 ? 4'd9 : (digits[3:0] - 4'd1);

    if (!b_s0)
      dec_val[7:4] = digits[7:4];
    else if (digits[7:4] == 4'd0)
      dec_val[7:4] = 4'd5;
    else
      dec_val[7:4] = digits[7:4] - 4'd1;

    if (!b_s1)
      dec_val[11:8] = digits[11:8];
    else if (digits[11:8] == 4'd0)
      dec_val[11:8] = 4'd9;
    else
      dec_val[11:8] = digits[11:8] - 4'd1;

    dec_val[15:12] = b_m0 ? (digits[15:12] - 4'd1) : digits[15:12];
  end

  // Command decode in priority order: load > stop > start > tick.
  always_comb begin
    do_load     = bus.load;
    do_stop     = !bus.load && bus.stop;
    do_start    = !bus.load && !bus.stop && bus.start &&
                  ((state == IDLE) || (state == PAUSE));
    do_tick     = !bus.load && !bus.stop && bus.tick && (state == RUN);
    digits_zero = (digits == 16'h0000);
    expire      = do_tick && (dec_val == 16'h0000);
    reload_ok   = AUTO_RELOAD && (preset != 16'h0000);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (do_load)
      state_nxt = IDLE;
    else if (do_stop) begin
      if (state == RUN)
        state_nxt = PAUSE;
    end
    else if (do_start)
      state_nxt = digits_zero ? DONE : RUN;
    else if (expire)
      state_nxt = reload_ok ? RUN : DONE;
  end

  // Datapath / output next values
  always_comb begin
    digits_nxt = digits;
    preset_nxt = preset;
    pulse_nxt  = 1'b0;
    if (do_load) begin
      digits_nxt = clamped;
      preset_nxt = clamped;
    end
    else if (do_start) begin
      pulse_nxt = digits_zero;
    end
    else if (expire) begin
      // With auto-reload the 0000 value is skipped and the preset appears directly.
      digits_nxt = reload_ok ? preset : 16'h0000;
      pulse_nxt  = 1'b1;
    end
    else if (do_tick) begin
      digits_nxt = dec_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits  <= 16'h0000;
      preset  <= 16'h0000;
      pulse_q <= 1'b0;
    end
    else begin
      digits  <= digits_nxt;
      preset  <= preset_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  assign bus.m1         = digits[15:12];
  assign bus.m0         = digits[11:8];
  assign bus.s1         = digits[7:4];
  assign bus.s0         = digits[3:0];
  assign bus.running    = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.done_pulse = pulse_q;
  assign bus.fsm_state  = state;

  // Digits always hold legal BCD; RUN never sits at 00:00.
  assert property (@(posedge clk) disable iff (reset)
    (digits[3:0] <= 4'd9) && (digits[7:4] <= 4'd5) &&
    (digits[11:8] <= 4'd9) && (digits[15:12] <= 4'd9));
  assert property (@(posedge clk) disable iff (reset)
    (state == RUN) |-> (digits != 16'h0000));

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: vector table for single-cycle behaviour plus
// hand sequences for full expiry, reset mid-count and auto-reload.
module tb_countdown_timer;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [15:0] exp_q[$];

  countdown_timer_if bus_a ();
  countdown_timer_if bus_r ();

  countdown_timer #(.AUTO_RELOAD(1'b0)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  countdown_timer #(.AUTO_RELOAD(1'b1)) u_dut_ar (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_r.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tick;
    logic        load;
    logic        start;
    logic        stop;
    logic [15:0] set;
    logic [15:0] exp_d;
    logic        exp_run;
    logic        exp_done;
    logic        exp_pulse;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] digits_a();
    return {bus_a.m1, bus_a.m0, bus_a.s1, bus_a.s0};
  endfunction

  function automatic logic [15:0] digits_r();
    return {bus_r.m1, bus_r.m0, bus_r.s1, bus_r.s0};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic t, input logic l, input logic st, input logic sp,
                         input logic [15:0] set);
    bus_a.tick   = t;
    bus_a.load   = l;
    bus_a.start  = st;
    bus_a.stop   = sp;
    bus_a.set_m1 = set[15:12];
    bus_a.set_m0 = set[11:8];
    bus_a.set_s1 = set[7:4];
    bus_a.set_s0 = set[3:0];
  endtask

  task automatic drive_r(input logic t, input logic l, input logic st, input logic sp,
                         input logic [15:0] set);
    bus_r.tick   = t;
    bus_r.load   = l;
    bus_r.start  = st;
    bus_r.stop   = sp;
    bus_r.set_m1 = set[15:12];
    bus_r.set_m0 = set[11:8];
    bus_r.set_s1 = set[7:4];
    bus_r.set_s0 = set[3:0];
  endtask

  task automatic check_a(input string name, input logic [15:0] d, input logic run,
                         input logic dn, input logic pl, input logic [1:0] st);
    check({name, ".digits"}, digits_a(), d);
    check({name, ".running"}, 16'(bus_a.running), 16'(run));
    check({name, ".done"}, 16'(bus_a.done), 16'(dn));
    check({name, ".pulse"}, 16'(bus_a.done_pulse), 16'(pl));
    check({name, ".state"}, 16'(bus_a.fsm_state), 16'(st));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_a(0, 0, 0, 0, 16'h0000);
    drive_r(0, 0, 0, 0, 16'h0000);
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] to_bcd(input int secs);
    int mm;
    int ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    do_reset();
    check_a("reset", 16'h0000, 0, 0, 0, S_IDLE);
    check("reset_ar.digits", digits_r(), 16'h0000);

    // tick  load start stop  set      exp_d    run done pulse state
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, S_IDLE});
    vecs.push_back('{0, 1, 0, 0, 16'h347C, 16'h3459, 0, 0, 0, S_IDLE});
    vecs.push_back('{0, 1, 0, 0, 16'hCF59, 16'h9959, 0, 0, 0, S_IDLE});
    vecs.push_back('{0, 1, 0, 0, 16'h1000, 16'h1000, 0, 0, 0, S_IDLE});
    vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h1000, 1, 0, 0, S_RUN});
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0959, 1, 0, 0, S_RUN});
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0958, 1, 0, 0, S_RUN});
    vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h0957, 1, 0, 0, S_RUN});
    vecs.push_back('{1, 1, 0, 0, 16'h0005, 16'h0005, 0, 0, 0, S_IDLE});
    vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0005, 1, 0, 0, S_RUN});
    vecs.push_back('{1, 0, 0, 1, 16'h0000, 16'h0005, 0, 0, 0, S_PAUSE});
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0005, 0, 0, 0, S_PAUSE});
    vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0005, 1, 0, 0, S_RUN});
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0004, 1, 0, 0, S_RUN});
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0003, 1, 0, 0, S_RUN});
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0, S_RUN});
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0, S_RUN});
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, S_DONE});
    vecs.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, S_DONE});
    vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, S_DONE});
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, S_DONE});
    vecs.push_back('{0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, S_IDLE});
    vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 1, S_DONE});
    vecs.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, S_DONE});

    for (int i = 0; i < vecs.size(); i++) begin
      drive_a(vecs[i].tick, vecs[i].load, vecs[i].start, vecs[i].stop, vecs[i].set);
      step();
      check_a($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_run,
              vecs[i].exp_done, vecs[i].exp_pulse, vecs[i].exp_st);
    end

    // Basic expiry: 01:00 with tick held high for 60 consecutive cycles.
    drive_a(0, 1, 0, 0, 16'h0100);
    step();
    drive_a(0, 0, 1, 0, 16'h0000);
    step();
    check_a("exp_start", 16'h0100, 1, 0, 0, S_RUN);
    drive_a(1, 0, 0, 0, 16'h0000);
    for (int k = 1; k <= 60; k++) begin
      exp_q.push_back(to_bcd(60 - k));
      step();
      check($sformatf("exp_tick%0d.digits", k), digits_a(), exp_q.pop_front());
      check($sformatf("exp_tick%0d.done", k), 16'(bus_a.done), 16'(k == 60));
      check($sformatf("exp_tick%0d.pulse", k), 16'(bus_a.done_pulse), 16'(k == 60));
    end
    step();
    check_a("exp_after", 16'h0000, 0, 1, 0, S_DONE);
    drive_a(0, 0, 0, 0, 16'h0000);

    // Reset mid-count returns to a cleared IDLE.
    drive_a(0, 1, 0, 0, 16'h0500);
    step();
    drive_a(0, 0, 1, 0, 16'h0000);
    step();
    drive_a(1, 0, 0, 0, 16'h0000);
    step();
    step();
    check("midcount.digits", digits_a(), 16'h0458);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive_a(0, 0, 0, 0, 16'h0000);
    check_a("midreset", 16'h0000, 0, 0, 0, S_IDLE);

    // Auto-reload with preset 00:02: 01, 02+pulse, 01, 02+pulse, done never set.
    drive_r(0, 1, 0, 0, 16'h0002);
    step();
    drive_r(0, 0, 1, 0, 16'h0000);
    step();
    check("ar_start.running", 16'(bus_r.running), 16'd1);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    drive_r(1, 0, 0, 0, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("ar_tick%0d.digits", k), digits_r(), exp_q.pop_front());
      check($sformatf("ar_tick%0d.pulse", k), 16'(bus_r.done_pulse), 16'((k % 2) == 0));
      check($sformatf("ar_tick%0d.done", k), 16'(bus_r.done), 16'd0);
      check($sformatf("ar_tick%0d.running", k), 16'(bus_r.running), 16'd1);
    end
    drive_r(0, 0, 0, 0, 16'h0000);
    step();
    check("ar_idle.pulse", 16'(bus_r.done_pulse), 16'd0);

    // Auto-reload with preset 00:00 has nothing to reload: start goes straight to DONE.
    drive_r(0, 1, 0, 0, 16'h0000);
    step();
    drive_r(0, 0, 1, 0, 16'h0000);
    step();
    check("ar_zero.done", 16'(bus_r.done), 16'd1);
    check("ar_zero.pulse", 16'(bus_r.done_pulse), 16'd1);
    drive_r(0, 0, 0, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
